usb_packet_parser: RTL and testbench
====================================

# usb_packet_parser

Packet-level parser directly downstream of the bit/byte packet decoder. It consumes the decoder's byte stream, PID and end-of-packet/CRC verdict, and classifies each packet as token, SOF, data or handshake. Token fields and frame numbers are extracted, and data payloads are forwarded byte-by-byte with the two CRC16 bytes stripped. Its outputs feed the device-side endpoint/transaction engine.

## Interface
- MAX_PAYLOAD, default 64: maximum data payload bytes, excluding CRC; legal range 1..1023.
- clk48  in  1  48 MHz clock
- reset  in  1  synchronous reset, active-high
- byte_in  in  8  decoded byte, LSB first on the wire
- byte_in_valid  in  1  one-cycle strobe per byte
- pid_in  in  4  PID nibble from the decoder
- pid_in_valid  in  1  high while the PID is checked-good and payload is in progress
- pkt_eop  in  1  one-cycle end-of-packet strobe
- pkt_ok  in  1  PID and CRC good; qualified by pkt_eop
- tok_valid  out  1  pulse: OUT/IN/SETUP token accepted
- tok_pid  out  4  token PID
- tok_addr  out  7  device address
- tok_endp  out  4  endpoint number
- sof_valid  out  1  pulse: SOF accepted
- frame_num  out  11  SOF frame number
- hs_valid  out  1  pulse: ACK/NAK/STALL/NYET received
- hs_pid  out  4  handshake PID
- data_start  out  1  pulse: DATA0/DATA1 packet begins
- data_pid  out  4  DATA0 or DATA1
- data_byte  out  8  payload byte
- data_byte_valid  out  1  payload byte strobe
- data_end  out  1  pulse: data packet finished
- data_ok  out  1  qualified by data_end: CRC good, no length error
- data_len  out  11  payload byte count; qualified by data_end
- err_valid  out  1  pulse: packet rejected
- err_code  out  3  1 no PID, 2 CRC, 3 length, 4 overflow, 5 unsupported PID

## Operation
- States: IDLE, TOKEN, HSHK, DATA, DISCARD, DONE.
- IDLE: first cycle with pid_in_valid latches pid_in and selects the next state.
  - OUT/IN/SETUP/SOF go to TOKEN.
  - DATA0/DATA1 go to DATA and emit data_start with data_pid set.
  - ACK/NAK/STALL/NYET go to HSHK.
  - Any other PID goes to DISCARD with pending code 5.
  - pkt_eop while in IDLE raises err code 1 and leaves the state at IDLE.
- TOKEN: stores up to 2 bytes. tok_addr = b0[6:0]; tok_endp = {b1[2:0], b0[7]}; frame_num = {b1[2:0], b0}. At eop, the packet is valid only if exactly 2 bytes arrived and pkt_ok is high; otherwise err code 2 (CRC) takes priority over code 3 (length).
- HSHK: at eop, requires 0 bytes; otherwise err 3.
- DATA: 2-byte delay line. Each incoming byte, once 2 bytes are already held, pushes out the oldest as data_byte, and data_len increments.
  - If the count of emitted bytes would exceed MAX_PAYLOAD, go to DISCARD with pending code 4; nothing further is emitted.
  - At eop: data_end pulses with data_ok = pkt_ok && received ≥ 2 bytes.
  - If fewer than 2 bytes were received: err 3.
  - If pkt_ok is low: err 2.
  - Zero-length packet (exactly 2 CRC bytes): data_end, data_len = 0, data_ok = 1.
- DISCARD: ignores bytes. At eop: err with pending code; data_end with data_ok = 0 if the packet was a data packet.
- DONE: one cycle in which result pulses are driven, then return to IDLE.
- Field outputs (tok_*, frame_num, hs_pid, data_pid, data_len) hold their value until overwritten by the next accepted packet.

## Timing
- Reset: all outputs 0, state IDLE, delay line and counters cleared. Reset mid-packet abandons the packet with no pulses; the next packet starts clean.
- data_start: 1 cycle after the pid_in_valid rising cycle.
- data_byte_valid: registered, 1 cycle after the byte_in_valid that pushes the byte out. Payload byte k is emitted after byte k+2 arrives; the 2 CRC bytes are never emitted.
- tok_valid / sof_valid / hs_valid / data_end / err_valid: single-cycle pulses, 1 cycle after pkt_eop (the DONE cycle).
- Exactly one result pulse per packet. The one exception is a failed data packet, which pulses data_end together with err_valid.
- byte_in_valid and pkt_eop in the same cycle: the byte is processed first, then the eop is evaluated.
- pid_in_valid high while not in IDLE is ignored; the PID is latched once per packet.
- Back-to-back packets: a new pid_in_valid arriving in the DONE cycle is taken on the next cycle, since pid_in_valid stays high through the payload.

## Structure
- Shared package usb_pkg holds:
  - PID localparams: OUT 0001, IN 1001, SOF 0101, SETUP 1101, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110, NYET 0110.
  - Error code constants.
  - State encoding.
- Sub-module usb_crc_strip: the 2-byte delay line with push/flush/clear, emit strobe and held-count. Reused later for the transmit path.

## Test plan
- OUT token, bytes 0x85, 0x40, pkt_ok=1 → tok_valid, tok_addr=0x05, tok_endp=0x1 (b1[2:0]=0, b0[7]=1), tok_pid=0001.
- SOF, bytes 0x34, 0x02, pkt_ok=1 → sof_valid, frame_num=0x234.
- DATA1, bytes 0x11 0x22 0x33 plus 2 CRC bytes, pkt_ok=1 → data_start; data_byte 0x11, 0x22, 0x33 only; data_end with data_len=3 and data_ok=1.
- DATA0 with MAX_PAYLOAD=4 and 8 bytes → 4 bytes emitted, then err code 4, data_end with data_ok=0.
- ACK with 1 stray byte → err code 3, no hs_valid. IN token with pkt_ok=0 → err code 2.
- pkt_eop in IDLE → err code 1. Reset asserted mid-DATA → no data_end, all outputs 0, and the following token is decoded correctly.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB packet definitions: PID values, parser error codes, parser state encoding.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_NYET  = 4'b0110;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_NOPID = 3'd1;
    localparam logic [2:0] ERR_CRC   = 3'd2;
    localparam logic [2:0] ERR_LEN   = 3'd3;
    localparam logic [2:0] ERR_OVF   = 3'd4;
    localparam logic [2:0] ERR_PID   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOKEN,
        ST_HSHK,
        ST_DATA,
        ST_DISCARD,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        PK_TOKEN,
        PK_HSHK,
        PK_DATA,
        PK_OTHER
    } pid_class_t;

    // SOF shares the token layout (two field bytes), so it is classed as a token.
    function automatic pid_class_t pid_class(input logic [3:0] pid);
        case (pid)
            PID_OUT, PID_IN, PID_SETUP, PID_SOF:     return PK_TOKEN;
            PID_ACK, PID_NAK, PID_STALL, PID_NYET:   return PK_HSHK;
            PID_DATA0, PID_DATA1:                    return PK_DATA;
            default:                                 return PK_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/usb_packet_parser_if.sv
// Decoder-to-parser byte stream plus the parser's packet-level results.
interface usb_packet_parser_if;

    logic [7:0]  byte_in;
    logic        byte_in_valid;
    logic [3:0]  pid_in;
    logic        pid_in_valid;
    logic        pkt_eop;
    logic        pkt_ok;

    logic        tok_valid;
    logic [3:0]  tok_pid;
    logic [6:0]  tok_addr;
    logic [3:0]  tok_endp;
    logic        sof_valid;
    logic [10:0] frame_num;
    logic        hs_valid;
    logic [3:0]  hs_pid;
    logic        data_start;
    logic [3:0]  data_pid;
    logic [7:0]  data_byte;
    logic        data_byte_valid;
    logic        data_end;
    logic        data_ok;
    logic [10:0] data_len;
    logic        err_valid;
    logic [2:0]  err_code;

    modport master (
        output byte_in, byte_in_valid, pid_in, pid_in_valid, pkt_eop, pkt_ok,
        input  tok_valid, tok_pid, tok_addr, tok_endp, sof_valid, frame_num,
        input  hs_valid, hs_pid, data_start, data_pid, data_byte, data_byte_valid,
        input  data_end, data_ok, data_len, err_valid, err_code
    );

    modport slave (
        input  byte_in, byte_in_valid, pid_in, pid_in_valid, pkt_eop, pkt_ok,
        output tok_valid, tok_pid, tok_addr, tok_endp, sof_valid, frame_num,
        output hs_valid, hs_pid, data_start, data_pid, data_byte, data_byte_valid,
        output data_end, data_ok, data_len, err_valid, err_code
    );

endinterface

// File: rtl/usb_crc_strip.sv
// Two-byte delay line: bytes only leave once two newer bytes are held behind them,
// so the trailing CRC16 pair is never emitted.
module usb_crc_strip (
    input  logic       clk48,
    input  logic       reset,
    input  logic       clear,
    input  logic       flush,
    input  logic       push,
    input  logic [7:0] din,
    output logic       emit,
    output logic [7:0] dout,
    output logic [1:0] held
);

    logic [7:0] d0;
    logic [7:0] d1;

    always_ff @(posedge clk48) begin
        if (reset) begin
            d0   <= 8'd0;
            d1   <= 8'd0;
            held <= 2'd0;
            emit <= 1'b0;
            dout <= 8'd0;
        end else if (clear) begin
            held <= 2'd0;
            emit <= 1'b0;
        end else begin
            emit <= 1'b0;
            if (push) begin
                case (held)
                    2'd0: begin
                        d0   <= din;
                        held <= 2'd1;
                    end
                    2'd1: begin
                        d1   <= din;
                        held <= 2'd2;
                    end
                    default: begin
                        dout <= d0;
                        emit <= 1'b1;
                        d0   <= d1;
                        d1   <= din;
                    end
                endcase
            end
            // A push in the same cycle still emits; only the held pair is dropped.
            if (flush) held <= 2'd0;
        end
    end

endmodule

// File: rtl/usb_packet_parser.sv
// Classifies decoded USB packets (token/SOF/data/handshake), extracts token fields
// and streams data payloads with the CRC16 stripped.
module usb_packet_parser
    import usb_pkg::*;
#(
    parameter int MAX_PAYLOAD = 64
) (
    input logic                clk48,
    input logic                reset,
    usb_packet_parser_if.slave bus
);

    localparam logic [10:0] MAXP = 11'(MAX_PAYLOAD);

    state_t      state;
    logic [3:0]  pid_r;
    logic [2:0]  pend;
    logic        is_data;
    logic [1:0]  rx_cnt;
    logic [7:0]  b0;
    logic [2:0]  b1_lo;
    logic [10:0] emit_cnt;

    logic [1:0]  rx_eff;
    logic [7:0]  b0_eff;
    logic [2:0]  b1_eff;
    logic [1:0]  held;
    logic        pushes_out;
    logic        ovf;
    logic        push;
    logic        flush;
    logic        clear;
    logic [10:0] emit_eff;

    // The *_eff values fold in a byte arriving in the same cycle as pkt_eop.
    always_comb begin
        rx_eff = rx_cnt;
        if (bus.byte_in_valid && rx_cnt != 2'd3) rx_eff = rx_cnt + 2'd1;
        b0_eff     = (bus.byte_in_valid && rx_cnt == 2'd0) ? bus.byte_in : b0;
        b1_eff     = (bus.byte_in_valid && rx_cnt == 2'd1) ? bus.byte_in[2:0] : b1_lo;
        pushes_out = (state == ST_DATA) && bus.byte_in_valid && (held == 2'd2);
        ovf        = pushes_out && (emit_cnt == MAXP);
        push       = (state == ST_DATA) && bus.byte_in_valid && !ovf;
        emit_eff   = (push && held == 2'd2) ? emit_cnt + 11'd1 : emit_cnt;
        flush      = (state == ST_DATA) && bus.pkt_eop;
        clear      = (state == ST_IDLE);
    end

    usb_crc_strip u_strip (
        .clk48 (clk48),
        .reset (reset),
        .clear (clear),
        .flush (flush),
        .push  (push),
        .din   (bus.byte_in),
        .emit  (bus.data_byte_valid),
        .dout  (bus.data_byte),
        .held  (held)
    );

    always_ff @(posedge clk48) begin
        if (reset) begin
            state          <= ST_IDLE;
            pid_r          <= 4'd0;
            pend           <= ERR_NONE;
            is_data        <= 1'b0;
            rx_cnt         <= 2'd0;
            b0             <= 8'd0;
            b1_lo          <= 3'd0;
            emit_cnt       <= 11'd0;
            bus.tok_valid  <= 1'b0;
            bus.tok_pid    <= 4'd0;
            bus.tok_addr   <= 7'd0;
            bus.tok_endp   <= 4'd0;
            bus.sof_valid  <= 1'b0;
            bus.frame_num  <= 11'd0;
            bus.hs_valid   <= 1'b0;
            bus.hs_pid     <= 4'd0;
            bus.data_start <= 1'b0;
            bus.data_pid   <= 4'd0;
            bus.data_end   <= 1'b0;
            bus.data_ok    <= 1'b0;
            bus.data_len   <= 11'd0;
            bus.err_valid  <= 1'b0;
            bus.err_code   <= ERR_NONE;
        end else begin
            bus.tok_valid  <= 1'b0;
            bus.sof_valid  <= 1'b0;
            bus.hs_valid   <= 1'b0;
            bus.data_start <= 1'b0;
            bus.data_end   <= 1'b0;
            bus.err_valid  <= 1'b0;

            if (bus.byte_in_valid) begin
                rx_cnt <= rx_eff;
                if (rx_cnt == 2'd0) b0 <= bus.byte_in;
                if (rx_cnt == 2'd1) b1_lo <= bus.byte_in[2:0];
            end
            if (push && held == 2'd2) emit_cnt <= emit_eff;

            case (state)
                ST_IDLE: begin
                    rx_cnt   <= 2'd0;
                    emit_cnt <= 11'd0;
                    if (bus.pkt_eop) begin
                        bus.err_valid <= 1'b1;
                        bus.err_code  <= ERR_NOPID;
                    end else if (bus.pid_in_valid) begin
                        pid_r   <= bus.pid_in;
                        is_data <= 1'b0;
                        case (pid_class(bus.pid_in))
                            PK_TOKEN: state <= ST_TOKEN;
                            PK_HSHK:  state <= ST_HSHK;
                            PK_DATA: begin
                                state          <= ST_DATA;
                                is_data        <= 1'b1;
                                bus.data_start <= 1'b1;
                                bus.data_pid   <= bus.pid_in;
                            end
                            default: begin
                                state <= ST_DISCARD;
                                pend  <= ERR_PID;
                            end
                        endcase
                    end
                end

                ST_TOKEN: begin
                    if (bus.pkt_eop) begin
                        state <= ST_DONE;
                        if (bus.pkt_ok && rx_eff == 2'd2) begin
                            if (pid_r == PID_SOF) begin
                                bus.sof_valid <= 1'b1;
                                bus.frame_num <= {b1_eff, b0_eff};
                            end else begin
                                bus.tok_valid <= 1'b1;
                                bus.tok_pid   <= pid_r;
                                bus.tok_addr  <= b0_eff[6:0];
                                bus.tok_endp  <= {b1_eff, b0_eff[7]};
                            end
                        end else begin
                            bus.err_valid <= 1'b1;
                            bus.err_code  <= bus.pkt_ok ? ERR_LEN : ERR_CRC;
                        end
                    end
                end

                ST_HSHK: begin
                    if (bus.pkt_eop) begin
                        state <= ST_DONE;
                        if (rx_eff == 2'd0) begin
                            bus.hs_valid <= 1'b1;
                            bus.hs_pid   <= pid_r;
                        end else begin
                            bus.err_valid <= 1'b1;
                            bus.err_code  <= ERR_LEN;
                        end
                    end
                end

                ST_DATA: begin
                    if (ovf) begin
                        if (bus.pkt_eop) begin
                            state         <= ST_DONE;
                            bus.err_valid <= 1'b1;
                            bus.err_code  <= ERR_OVF;
                            bus.data_end  <= 1'b1;
                            bus.data_ok   <= 1'b0;
                            bus.data_len  <= emit_cnt;
                        end else begin
                            state <= ST_DISCARD;
                            pend  <= ERR_OVF;
                        end
                    end else if (bus.pkt_eop) begin
                        state        <= ST_DONE;
                        bus.data_end <= 1'b1;
                        bus.data_len <= emit_eff;
                        bus.data_ok  <= bus.pkt_ok && (rx_eff >= 2'd2);
                        // CRC failure outranks a short packet, matching the token path.
                        if (!bus.pkt_ok) begin
                            bus.err_valid <= 1'b1;
                            bus.err_code  <= ERR_CRC;
                        end else if (rx_eff < 2'd2) begin
                            bus.err_valid <= 1'b1;
                            bus.err_code  <= ERR_LEN;
                        end
                    end
                end

                ST_DISCARD: begin
                    if (bus.pkt_eop) begin
                        state         <= ST_DONE;
                        bus.err_valid <= 1'b1;
                        bus.err_code  <= pend;
                        if (is_data) begin
                            bus.data_end <= 1'b1;
                            bus.data_ok  <= 1'b0;
                            bus.data_len <= emit_cnt;
                        end
                    end
                end

                ST_DONE: state <= ST_IDLE;

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_packet_parser.sv
// Packet-level bench: directed table, hand sequences and random packets against a spec model.
module tb_usb_packet_parser;

    localparam int MAXP = 4;

    logic clk48 = 1'b0;
    logic reset;
    always #10 clk48 = ~clk48;

    usb_packet_parser_if bus ();

    usb_packet_parser #(.MAX_PAYLOAD(MAXP)) dut (
        .clk48 (clk48),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]       pid;
        int               n;
        logic [7:0][7:0]  b;
        bit               ok;
        bit               eol;
        bit               e_tok, e_sof, e_hs, e_ds, e_de, e_err;
        logic [2:0]       e_code;
        logic [6:0]       e_addr;
        logic [3:0]       e_endp;
        logic [10:0]      e_frame;
        bit               e_dok;
        logic [10:0]      e_len;
        int               e_nb;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Monitor: cumulative pulse counts and last-seen field values.
    int c_tok = 0, c_sof = 0, c_hs = 0, c_ds = 0, c_de = 0, c_err = 0;
    logic [3:0]  m_tpid, m_hpid, m_dpid;
    logic [6:0]  m_addr;
    logic [3:0]  m_endp;
    logic [10:0] m_frame, m_len;
    logic        m_dok;
    logic [2:0]  m_code;
    logic [7:0]  q_bytes[$];

    always @(negedge clk48) begin
        if (bus.tok_valid) begin c_tok++; m_tpid = bus.tok_pid; m_addr = bus.tok_addr; m_endp = bus.tok_endp; end
        if (bus.sof_valid) begin c_sof++; m_frame = bus.frame_num; end
        if (bus.hs_valid) begin c_hs++; m_hpid = bus.hs_pid; end
        if (bus.data_start) begin c_ds++; m_dpid = bus.data_pid; end
        if (bus.data_end) begin c_de++; m_dok = bus.data_ok; m_len = bus.data_len; end
        if (bus.err_valid) begin c_err++; m_code = bus.err_code; end
        if (bus.data_byte_valid) q_bytes.push_back(bus.data_byte);
    end

    int b_tok = 0, b_sof = 0, b_hs = 0, b_ds = 0, b_de = 0, b_err = 0, b_nb = 0;

    task automatic rebase();
        b_tok = c_tok; b_sof = c_sof; b_hs = c_hs; b_ds = c_ds; b_de = c_de; b_err = c_err;
        b_nb = q_bytes.size();
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk48);
        #1;
    endtask

    function automatic vec_t mk(logic [3:0] pid, int n, logic [63:0] bytes, bit ok, bit eol);
        vec_t v;
        v.pid = pid; v.n = n; v.b = bytes; v.ok = ok; v.eol = eol;
        v.e_tok = 0; v.e_sof = 0; v.e_hs = 0; v.e_ds = 0; v.e_de = 0; v.e_err = 0;
        v.e_code = 0; v.e_addr = 0; v.e_endp = 0; v.e_frame = 0;
        v.e_dok = 0; v.e_len = 0; v.e_nb = 0;
        return v;
    endfunction

    // pulses = {tok, sof, hs, data_start, data_end, err}
    function automatic vec_t ex(vec_t v, logic [5:0] pulses, logic [2:0] code, logic [6:0] addr,
                                logic [3:0] endp, logic [10:0] frame, bit dok, logic [10:0] len, int nb);
        vec_t r = v;
        {r.e_tok, r.e_sof, r.e_hs, r.e_ds, r.e_de, r.e_err} = pulses;
        r.e_code = code; r.e_addr = addr; r.e_endp = endp; r.e_frame = frame;
        r.e_dok = dok; r.e_len = len; r.e_nb = nb;
        return r;
    endfunction

    // Reference model: outcome of a whole packet from its PID, byte list and CRC verdict.
    function automatic vec_t model(vec_t v);
        vec_t r = v;
        int b0 = int'(v.b[0]);
        int b1 = int'(v.b[1]);
        int pay;
        if (v.n < 0) begin
            r.e_err = 1; r.e_code = 3'd1;
            return r;
        end
        case (v.pid)
            4'b0001, 4'b1001, 4'b1101, 4'b0101: begin
                if (v.ok && v.n == 2) begin
                    if (v.pid == 4'b0101) begin
                        r.e_sof = 1; r.e_frame = 11'((b1 % 8) * 256 + b0);
                    end else begin
                        r.e_tok = 1; r.e_addr = 7'(b0 % 128); r.e_endp = 4'((b1 % 8) * 2 + b0 / 128);
                    end
                end else begin
                    r.e_err = 1; r.e_code = v.ok ? 3'd3 : 3'd2;
                end
            end
            4'b0010, 4'b1010, 4'b1110, 4'b0110: begin
                if (v.n == 0) r.e_hs = 1;
                else begin r.e_err = 1; r.e_code = 3'd3; end
            end
            4'b0011, 4'b1011: begin
                r.e_ds = 1; r.e_de = 1;
                pay = (v.n > 2) ? v.n - 2 : 0;
                if (pay > MAXP) begin
                    r.e_nb = MAXP; r.e_len = 11'(MAXP); r.e_dok = 0;
                    r.e_err = 1; r.e_code = 3'd4;
                end else begin
                    r.e_nb = pay; r.e_len = 11'(pay); r.e_dok = v.ok && v.n >= 2;
                    if (!v.ok) begin r.e_err = 1; r.e_code = 3'd2; end
                    else if (v.n < 2) begin r.e_err = 1; r.e_code = 3'd3; end
                end
            end
            default: begin r.e_err = 1; r.e_code = 3'd5; end
        endcase
        return r;
    endfunction

    task automatic check_pkt(vec_t v, string tag);
        int got_nb;
        chk({tag, ".tok_cnt"}, c_tok - b_tok, v.e_tok);
        chk({tag, ".sof_cnt"}, c_sof - b_sof, v.e_sof);
        chk({tag, ".hs_cnt"},  c_hs - b_hs,   v.e_hs);
        chk({tag, ".dstart_cnt"}, c_ds - b_ds, v.e_ds);
        chk({tag, ".dend_cnt"}, c_de - b_de,  v.e_de);
        chk({tag, ".err_cnt"}, c_err - b_err, v.e_err);
        if (v.e_tok) begin
            chk({tag, ".tok_pid"},  m_tpid, v.pid);
            chk({tag, ".tok_addr"}, m_addr, v.e_addr);
            chk({tag, ".tok_endp"}, m_endp, v.e_endp);
        end
        if (v.e_sof) chk({tag, ".frame_num"}, m_frame, v.e_frame);
        if (v.e_hs)  chk({tag, ".hs_pid"}, m_hpid, v.pid);
        if (v.e_ds)  chk({tag, ".data_pid"}, m_dpid, v.pid);
        if (v.e_de) begin
            chk({tag, ".data_ok"},  m_dok, v.e_dok);
            chk({tag, ".data_len"}, m_len, v.e_len);
        end
        if (v.e_err) chk({tag, ".err_code"}, m_code, v.e_code);
        got_nb = q_bytes.size() - b_nb;
        chk({tag, ".nbytes"}, got_nb, v.e_nb);
        for (int i = 0; i < v.e_nb && i < got_nb; i++)
            chk($sformatf("%s.byte%0d", tag, i), q_bytes[b_nb + i], v.b[i]);
        rebase();
    endtask

    task automatic send(vec_t v, string tag);
        if (v.n >= 0) begin
            bus.pid_in = v.pid;
            bus.pid_in_valid = 1'b1;
            step();
            step();
            for (int i = 0; i < v.n; i++) begin
                bus.byte_in = v.b[i];
                bus.byte_in_valid = 1'b1;
                if (i == v.n - 1 && v.eol) begin
                    bus.pkt_eop = 1'b1; bus.pkt_ok = v.ok; bus.pid_in_valid = 1'b0;
                end
                step();
                bus.byte_in_valid = 1'b0;
                if (i != v.n - 1 && $urandom_range(0, 3) == 0) step();
            end
        end
        if (!(v.eol && v.n > 0)) begin
            bus.pkt_eop = 1'b1; bus.pkt_ok = v.ok; bus.pid_in_valid = 1'b0;
            step();
        end
        bus.pkt_eop = 1'b0; bus.pkt_ok = 1'b0; bus.byte_in_valid = 1'b0; bus.pid_in_valid = 1'b0;
        @(negedge clk48);
        #1;
        check_pkt(v, tag);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, ".pulses"}, {bus.tok_valid, bus.sof_valid, bus.hs_valid, bus.data_start,
                               bus.data_byte_valid, bus.data_end, bus.err_valid}, 0);
        chk({tag, ".tok_fields"}, {bus.tok_pid, bus.tok_addr, bus.tok_endp}, 0);
        chk({tag, ".frame_num"}, bus.frame_num, 0);
        chk({tag, ".pids"}, {bus.hs_pid, bus.data_pid}, 0);
        chk({tag, ".data_byte"}, bus.data_byte, 0);
        chk({tag, ".data_len_ok"}, {bus.data_len, bus.data_ok}, 0);
        chk({tag, ".err_code"}, bus.err_code, 0);
    endtask

    vec_t tbl[14];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [3:0] pid;
        int n;

        tbl[0]  = ex(mk(4'b0001, 2, 64'h4085, 1, 0), 6'b100000, 0, 7'h05, 4'h1, 0, 0, 0, 0);
        tbl[1]  = ex(mk(4'b0101, 2, 64'h0234, 1, 0), 6'b010000, 0, 0, 0, 11'h234, 0, 0, 0);
        tbl[2]  = ex(mk(4'b1011, 5, 64'hC2C1332211, 1, 0), 6'b000110, 0, 0, 0, 0, 1, 3, 3);
        tbl[3]  = ex(mk(4'b0011, 8, 64'h8877665544332211, 1, 0), 6'b000111, 4, 0, 0, 0, 0, 4, 4);
        tbl[4]  = ex(mk(4'b0010, 1, 64'h5A, 1, 0), 6'b000001, 3, 0, 0, 0, 0, 0, 0);
        tbl[5]  = ex(mk(4'b1001, 2, 64'h0301, 0, 0), 6'b000001, 2, 0, 0, 0, 0, 0, 0);
        tbl[6]  = ex(mk(4'b0000, -1, 64'h0, 0, 0), 6'b000001, 1, 0, 0, 0, 0, 0, 0);
        tbl[7]  = ex(mk(4'b0011, 2, 64'hBEEF, 1, 1), 6'b000110, 0, 0, 0, 0, 1, 0, 0);
        tbl[8]  = ex(mk(4'b1101, 2, 64'h07FF, 1, 1), 6'b100000, 0, 7'h7F, 4'hF, 0, 0, 0, 0);
        tbl[9]  = ex(mk(4'b1011, 1, 64'h99, 1, 0), 6'b000111, 3, 0, 0, 0, 0, 0, 0);
        tbl[10] = ex(mk(4'b0000, 3, 64'h123456, 1, 0), 6'b000001, 5, 0, 0, 0, 0, 0, 0);
        tbl[11] = ex(mk(4'b1010, 0, 64'h0, 1, 0), 6'b001000, 0, 0, 0, 0, 0, 0, 0);
        tbl[12] = ex(mk(4'b0011, 7, 64'h77665544332211, 1, 1), 6'b000111, 4, 0, 0, 0, 0, 4, 4);
        tbl[13] = ex(mk(4'b1011, 4, 64'hDDCCBBAA, 0, 0), 6'b000111, 2, 0, 0, 0, 0, 2, 2);

        bus.byte_in = 0; bus.byte_in_valid = 0; bus.pid_in = 0; bus.pid_in_valid = 0;
        bus.pkt_eop = 0; bus.pkt_ok = 0;
        reset = 1'b1;
        step(); step();
        @(negedge clk48);
        chk_zero("reset");
        reset = 1'b0;
        step();
        rebase();

        for (int i = 0; i < 14; i++) begin
            send(tbl[i], $sformatf("tbl%0d", i));
            step();
        end

        // Reset in the middle of a data packet: nothing completes, next token is clean.
        bus.pid_in = 4'b0011; bus.pid_in_valid = 1'b1;
        step(); step();
        for (int i = 0; i < 4; i++) begin
            bus.byte_in = 8'(8'hA0 + i); bus.byte_in_valid = 1'b1;
            step();
        end
        bus.byte_in_valid = 1'b0;
        @(negedge clk48);
        #1;
        chk("midrst.bytes_before", q_bytes.size() - b_nb, 2);
        rebase();
        reset = 1'b1; bus.pid_in_valid = 1'b0;
        step();
        @(negedge clk48);
        #1;
        chk_zero("midrst");
        reset = 1'b0;
        step(); step(); step();
        chk("midrst.no_dend", c_de - b_de, 0);
        chk("midrst.no_err", c_err - b_err, 0);
        rebase();
        send(model(mk(4'b0001, 2, 64'h0283, 1, 0)), "postrst");

        for (int k = 0; k < 40; k++) begin
            pid = 4'($urandom_range(0, 15));
            n = $urandom_range(0, 8);
            if ($urandom_range(0, 2) != 0) begin
                case (pid)
                    4'b0001, 4'b1001, 4'b1101, 4'b0101: n = 2;
                    4'b0010, 4'b1010, 4'b1110, 4'b0110: n = 0;
                    default: ;
                endcase
            end
            v = model(mk(pid, n, {$urandom, $urandom}, $urandom_range(0, 3) != 0,
                         1'($urandom_range(0, 1))));
            send(v, $sformatf("rnd%0d", k));
            repeat ($urandom_range(0, 2)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
